// File: rtl/fpadd_pkg.sv
// Shared definitions for the floating-point adder: default widths, the
// sequencer state encoding and the shift-amount width helper.
package fpadd_pkg;

   localparam int EXPBITS_DEFAULT      = 8;
   localparam int MANTISSABITS_DEFAULT = 23;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALIGN  = 3'd1,
      NORM   = 3'd2,
      ROUND  = 3'd3,
      RENORM = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Width of the FFO index and of every shift count.
   function automatic int nbits(input int mantissa_bits);
      return $clog2(mantissa_bits);
   endfunction

endpackage

// File: rtl/control.sv
// Sequencer for the floating-point adder datapath: align, normalize,
// round/renormalize loop, result. Outputs decode State plus live status flags.
module control
   import fpadd_pkg::*;
#(
   parameter int EXPBITS      = EXPBITS_DEFAULT,
   parameter int MANTISSABITS = MANTISSABITS_DEFAULT,
   localparam int NBITS       = nbits(MANTISSABITS)
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Go,
   input  logic                    ExpSet,
   input  logic [EXPBITS-1:0]      ExpDiff,
   input  logic                    FFOValid,
   input  logic [NBITS-1:0]        FFOIndex,
   input  logic [MANTISSABITS+1:0] Out,
   output logic                    SelExpMux,
   output logic                    SelSRMuxL,
   output logic                    SelSRMuxG,
   output logic                    ShiftRightEnable,
   output logic [NBITS-1:0]        ShiftRightAmount,
   output logic                    SREn,
   output logic                    SLEn,
   output logic                    NoShift,
   output logic                    IncrEn,
   output logic                    DecrEn,
   output logic [NBITS-1:0]        ShiftAmount,
   output logic                    SelExpMuxR,
   output logic                    SelManMuxR,
   output logic                    Result
);

   localparam logic [NBITS-1:0]   HIDDEN_IDX  = NBITS'(MANTISSABITS);
   localparam logic [NBITS-1:0]   CARRY_IDX   = NBITS'(MANTISSABITS + 1);
   localparam logic [EXPBITS-1:0] ALIGN_LIMIT = EXPBITS'(MANTISSABITS + 1);

   state_t State;
   state_t w_next_state;

   // Only the carry bit of the rounded mantissa steers the sequencer.
   logic w_unused_out;
   assign w_unused_out = ^Out[MANTISSABITS:0];

   // NOTE: every output and the next state get a default before the case,
   // so no path through this block can leave a value held (no latches).
   always_comb begin
      w_next_state     = State;
      SelExpMux        = 1'b0;
      SelSRMuxL        = 1'b0;
      SelSRMuxG        = 1'b0;
      ShiftRightEnable = 1'b0;
      ShiftRightAmount = '0;
      SREn             = 1'b0;
      SLEn             = 1'b0;
      NoShift          = 1'b0;
      IncrEn           = 1'b0;
      DecrEn           = 1'b0;
      ShiftAmount      = '0;
      SelExpMuxR       = 1'b0;
      SelManMuxR       = 1'b0;
      Result           = 1'b0;

      case (State)
         IDLE: begin
            if (Go) w_next_state = ALIGN;
         end

         ALIGN: begin
            SelExpMux        = ExpSet;
            SelSRMuxG        = ExpSet;
            SelSRMuxL        = ~ExpSet;
            ShiftRightEnable = 1'b1;
            // Shifting past hidden bit and carry leaves nothing, so saturate.
            ShiftRightAmount = (ExpDiff <= ALIGN_LIMIT) ? NBITS'(ExpDiff) : CARRY_IDX;
            w_next_state     = NORM;
         end

         NORM: begin
            if (!FFOValid) begin
               NoShift = 1'b1;
            end else if (FFOIndex == CARRY_IDX) begin
               SREn        = 1'b1;
               IncrEn      = 1'b1;
               ShiftAmount = NBITS'(1);
            end else if (FFOIndex < HIDDEN_IDX) begin
               SLEn        = 1'b1;
               DecrEn      = 1'b1;
               ShiftAmount = HIDDEN_IDX - FFOIndex;
            end else begin
               // Leading one already at the hidden bit, or an illegal index.
               NoShift = 1'b1;
            end
            w_next_state = ROUND;
         end

         ROUND: begin
            w_next_state = Out[MANTISSABITS+1] ? RENORM : DONE;
         end

         RENORM: begin
            SelExpMuxR   = 1'b1;
            SelManMuxR   = 1'b1;
            SREn         = 1'b1;
            IncrEn       = 1'b1;
            ShiftAmount  = NBITS'(1);
            w_next_state = ROUND;
         end

         DONE: begin
            Result       = 1'b1;
            SelExpMuxR   = 1'b1;
            SelManMuxR   = 1'b1;
            w_next_state = Go ? ALIGN : IDLE;
         end

         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop
   // samples its input from before the edge.
   always_ff @(posedge Clock) begin
      if (Reset) State <= IDLE;
      else       State <= w_next_state;
   end

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the adder sequencer; every cycle the full
// output bundle is compared against a hand-derived expected vector.
module tb_control;

   localparam int EXPBITS      = 8;
   localparam int MANTISSABITS = 23;
   localparam int NBITS        = 5;

   logic                    Clock = 1'b0;
   logic                    Reset;
   logic                    Go;
   logic                    ExpSet;
   logic [EXPBITS-1:0]      ExpDiff;
   logic                    FFOValid;
   logic [NBITS-1:0]        FFOIndex;
   logic [MANTISSABITS+1:0] Out;
   logic                    SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable;
   logic [NBITS-1:0]        ShiftRightAmount, ShiftAmount;
   logic                    SREn, SLEn, NoShift, IncrEn, DecrEn;
   logic                    SelExpMuxR, SelManMuxR, Result;

   int checks = 0;
   int errors = 0;

   control #(.EXPBITS(EXPBITS), .MANTISSABITS(MANTISSABITS)) dut (
      .Clock(Clock), .Reset(Reset), .Go(Go), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
      .FFOValid(FFOValid), .FFOIndex(FFOIndex), .Out(Out),
      .SelExpMux(SelExpMux), .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
      .ShiftRightEnable(ShiftRightEnable), .ShiftRightAmount(ShiftRightAmount),
      .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift), .IncrEn(IncrEn), .DecrEn(DecrEn),
      .ShiftAmount(ShiftAmount), .SelExpMuxR(SelExpMuxR), .SelManMuxR(SelManMuxR),
      .Result(Result)
   );

   always #5 Clock = ~Clock;

   logic [21:0] w_obs;
   assign w_obs = {SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount,
                   SREn, SLEn, NoShift, IncrEn, DecrEn, ShiftAmount,
                   SelExpMuxR, SelManMuxR, Result};

   // Bundle layout: sem sl sg sre sra[5] sren slen nos inc dec sa[5] semr smr res
   function automatic logic [21:0] pk(input bit sem, input bit sl, input bit sg,
                                      input bit sre, input int sra, input bit sren,
                                      input bit slen, input bit nos, input bit inc,
                                      input bit dec, input int sa, input bit semr,
                                      input bit smr, input bit res);
      logic [4:0] sra5, sa5;
      sra5 = sra[4:0];
      sa5  = sa[4:0];
      return {sem, sl, sg, sre, sra5, sren, slen, nos, inc, dec, sa5, semr, smr, res};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_out(input logic [1:0] top);
      Out = {top, {MANTISSABITS{1'b0}}};
   endtask

   logic [21:0] v_zero, v_noshift, v_round, v_renorm, v_done;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      v_zero    = '0;
      v_noshift = pk(0,0,0,0, 0, 0,0,1,0,0, 0, 0,0,0);
      v_round   = '0;
      v_renorm  = pk(0,0,0,0, 0, 1,0,0,1,0, 1, 1,1,0);
      v_done    = pk(0,0,0,0, 0, 0,0,0,0,0, 0, 1,1,1);

      Reset = 1'b1; Go = 1'b0; ExpSet = 1'b0; ExpDiff = '0;
      FFOValid = 1'b0; FFOIndex = '0; set_out(2'b00);
      step(); step();
      check("reset_outputs", 32'(w_obs), 32'(v_zero));
      Reset = 1'b0;
      step();
      check("idle_quiet", 32'(w_obs), 32'(v_zero));

      // 1: saturated align, leading one at hidden bit, no rounding carry.
      Go = 1'b1; ExpSet = 1'b1; ExpDiff = 8'h55;
      #1 check("t1_idle_go", 32'(w_obs), 32'(v_zero));
      step();
      check("t1_align", 32'(w_obs), 32'(pk(1,0,1,1, 24, 0,0,0,0,0, 0, 0,0,0)));
      Go = 1'b0; FFOValid = 1'b1; FFOIndex = 5'd23;
      step();
      check("t1_norm", 32'(w_obs), 32'(v_noshift));
      set_out(2'b01);
      step();
      check("t1_round", 32'(w_obs), 32'(v_round));
      step();
      check("t1_result_lat4", 32'(w_obs), 32'(v_done));
      step();
      check("t1_back_idle", 32'(w_obs), 32'(v_zero));

      // 2: b larger, modest align, one-place left normalize.
      Go = 1'b1; ExpSet = 1'b0; ExpDiff = 8'd5;
      step();
      check("t2_align", 32'(w_obs), 32'(pk(0,1,0,1, 5, 0,0,0,0,0, 0, 0,0,0)));
      Go = 1'b0; FFOValid = 1'b1; FFOIndex = 5'd22;
      step();
      check("t2_norm_left1", 32'(w_obs), 32'(pk(0,0,0,0, 0, 0,1,0,0,1, 1, 0,0,0)));
      set_out(2'b01);
      step(); step();
      check("t2_done", 32'(w_obs), 32'(v_done));
      step();

      // 3: carry out of the add, one renormalize pass; ExpDiff at the limit.
      Go = 1'b1; ExpSet = 1'b1; ExpDiff = 8'd24;
      step();
      check("t3_align_limit", 32'(w_obs), 32'(pk(1,0,1,1, 24, 0,0,0,0,0, 0, 0,0,0)));
      Go = 1'b0; FFOValid = 1'b1; FFOIndex = 5'd24;
      step();
      check("t3_norm_right", 32'(w_obs), 32'(pk(0,0,0,0, 0, 1,0,0,1,0, 1, 0,0,0)));
      set_out(2'b10);
      step();
      check("t3_round1", 32'(w_obs), 32'(v_round));
      step();
      check("t3_renorm", 32'(w_obs), 32'(v_renorm));
      set_out(2'b01);
      step();
      check("t3_round2", 32'(w_obs), 32'(v_round));
      step();
      check("t3_done", 32'(w_obs), 32'(v_done));
      step();

      // 4: zero sum, ExpDiff just past the limit, leading one deep in the sum.
      Go = 1'b1; ExpSet = 1'b0; ExpDiff = 8'd25;
      step();
      check("t4_align_sat25", 32'(w_obs), 32'(pk(0,1,0,1, 24, 0,0,0,0,0, 0, 0,0,0)));
      Go = 1'b0; FFOValid = 1'b0; FFOIndex = 5'd3;
      step();
      check("t4_norm_zero", 32'(w_obs), 32'(v_noshift));
      FFOValid = 1'b1; FFOIndex = 5'd0;
      #1 check("t4_norm_idx0", 32'(w_obs), 32'(pk(0,0,0,0, 0, 0,1,0,0,1, 23, 0,0,0)));
      FFOIndex = 5'd30;
      #1 check("t4_norm_illegal", 32'(w_obs), 32'(v_noshift));
      set_out(2'b00);
      step(); step();
      check("t4_done", 32'(w_obs), 32'(v_done));
      step();

      // 5: two renormalize passes; Result must appear exactly 8 cycles after Go.
      Go = 1'b1; ExpSet = 1'b1; ExpDiff = 8'd1; FFOValid = 1'b1; FFOIndex = 5'd23;
      step();
      Go = 1'b0;
      step();
      set_out(2'b10);
      step();
      check("t5_round1", 32'(w_obs), 32'(v_round));
      step();
      check("t5_renorm1", 32'(w_obs), 32'(v_renorm));
      set_out(2'b11);
      step();
      check("t5_round2", 32'(w_obs), 32'(v_round));
      step();
      check("t5_renorm2", 32'(w_obs), 32'(v_renorm));
      set_out(2'b01);
      step();
      check("t5_round3", 32'(w_obs), 32'(v_round));
      step();
      check("t5_result_lat8", 32'(w_obs), 32'(v_done));
      step();
      check("t5_idle", 32'(w_obs), 32'(v_zero));

      // 6a: reset in NORM returns to IDLE on the next edge.
      Go = 1'b1; ExpSet = 1'b1; ExpDiff = 8'd2; FFOIndex = 5'd24;
      step();
      Go = 1'b0;
      step();
      Reset = 1'b1;
      #1 check("t6_norm_pre_reset", 32'(w_obs), 32'(pk(0,0,0,0, 0, 1,0,0,1,0, 1, 0,0,0)));
      step();
      check("t6_reset_idle", 32'(w_obs), 32'(v_zero));
      Reset = 1'b0;
      step();
      check("t6_stay_idle", 32'(w_obs), 32'(v_zero));

      // 6b: Go held throughout is ignored mid-op and restarts straight from DONE.
      Go = 1'b1; ExpSet = 1'b0; ExpDiff = 8'd7; FFOIndex = 5'd23; set_out(2'b00);
      step();
      check("t6_align_a", 32'(w_obs), 32'(pk(0,1,0,1, 7, 0,0,0,0,0, 0, 0,0,0)));
      step();
      check("t6_norm_go_ign", 32'(w_obs), 32'(v_noshift));
      step();
      check("t6_round_go_ign", 32'(w_obs), 32'(v_round));
      step();
      check("t6_done_go", 32'(w_obs), 32'(v_done));
      ExpSet = 1'b1; ExpDiff = 8'd3;
      step();
      check("t6_b2b_align", 32'(w_obs), 32'(pk(1,0,1,1, 3, 0,0,0,0,0, 0, 0,0,0)));
      Go = 1'b0;
      step(); step(); step();
      check("t6_b2b_done", 32'(w_obs), 32'(v_done));
      step();
      check("t6_final_idle", 32'(w_obs), 32'(v_zero));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
